// File: rtl/multi_dataflow_out_framer.sv
// Output framer: registers kernel output beats and tags end-of-line/end-of-frame, reporting frame completion.
// Latency 1 cycle input-to-output; input stalls whenever the output register is full and not being consumed.
module multi_dataflow_out_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    width_i,
    input  logic [CNT_WIDTH-1:0]    height_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [DATA_WIDTH/8-1:0] in_strb_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_eol_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    err_unexp_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic                   frame_done_d;
    logic [CNT_WIDTH-1:0]   width_q, height_q;
    logic [CNT_WIDTH-1:0]   col_q, row_q;
    logic                   in_hs, out_hs;
    logic                   start_ok, start_zero;
    logic                   is_eol, is_last;

    assign in_ready_o = (state_q == RUN) & (~out_valid_o | out_ready_i);
    assign in_hs      = in_valid_i & in_ready_o;
    assign out_hs     = out_valid_o & out_ready_i;
    assign busy_o     = (state_q != IDLE);

    assign start_ok   = (state_q == IDLE) & start_i & (width_i != '0) & (height_i != '0);
    assign start_zero = (state_q == IDLE) & start_i & ((width_i == '0) | (height_i == '0));

    // Dimensions are non-zero once latched, so the decrement cannot wrap.
    assign is_eol  = (col_q == width_q - CNT_WIDTH'(1));
    assign is_last = is_eol & (row_q == height_q - CNT_WIDTH'(1));

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok)   state_d = RUN;
                if (start_zero) frame_done_d = 1'b1;
            end
            RUN: begin
                if (in_hs && is_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_hs && out_last_o) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d      = IDLE;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            frame_done_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_o <= frame_done_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else if (clear_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (start_ok) begin
            width_q  <= width_i;
            height_q <= height_i;
            col_q    <= '0;
            row_q    <= '0;
        end else if (in_hs) begin
            if (is_eol) begin
                col_q <= '0;
                row_q <= is_last ? '0 : row_q + CNT_WIDTH'(1);
            end else begin
                col_q <= col_q + CNT_WIDTH'(1);
            end
        end
    end

    // Single-entry output register; a new beat may enter in the same cycle the held one leaves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_strb_o  <= '0;
            out_eol_o   <= 1'b0;
            out_last_o  <= 1'b0;
        end else if (clear_i) begin
            out_valid_o <= 1'b0;
            out_eol_o   <= 1'b0;
            out_last_o  <= 1'b0;
        end else if (in_hs) begin
            out_valid_o <= 1'b1;
            out_data_o  <= in_data_i;
            out_strb_o  <= in_strb_i;
            out_eol_o   <= is_eol;
            out_last_o  <= is_last;
        end else if (out_hs) begin
            out_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_unexp_o <= 1'b0;
        end else if (clear_i || start_ok) begin
            err_unexp_o <= 1'b0;
        end else if (in_valid_i && (state_q != RUN)) begin
            err_unexp_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_dataflow_out_framer.sv
// Bench for multi_dataflow_out_framer: directed scenarios plus random frames against a beat-list reference model.
module tb_multi_dataflow_out_framer;

    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk, rst_n, clear, start;
    logic [CW-1:0] width, height;
    logic [DW-1:0] in_data, out_data;
    logic [3:0]    in_strb, out_strb;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic          out_eol, out_last, busy, frame_done, err_unexp;

    multi_dataflow_out_framer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
        .width_i(width), .height_i(height),
        .in_data_i(in_data), .in_strb_i(in_strb), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_strb_o(out_strb), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_eol_o(out_eol), .out_last_o(out_last), .busy_o(busy),
        .frame_done_o(frame_done), .err_unexp_o(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [3:0]    s;
        logic          eol;
        logic          last;
    } beat_t;

    // Reference model: a frame is a list of w*h beats; beat k ends a line when k mod w == w-1.
    beat_t pend[$];
    bit    active, done_exp, err_exp;
    int    fw, fh, total, acc_cnt;
    int    n_cmp, n_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        active = 0; done_exp = 0; err_exp = 0; acc_cnt = 0; total = 0;
        pend.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),   0);
        chk({tag, "_out_valid"}, 64'(out_valid),  0);
        chk({tag, "_eol"},       64'(out_eol),    0);
        chk({tag, "_last"},      64'(out_last),   0);
        chk({tag, "_busy"},      64'(busy),       0);
        chk({tag, "_done"},      64'(frame_done), 0);
        chk({tag, "_err"},       64'(err_unexp),  0);
        chk({tag, "_data"},      64'(out_data),   0);
        chk({tag, "_strb"},      64'(out_strb),   0);
    endtask

    // One clock cycle: check the visible state, drive inputs, then advance the model to the next edge.
    task automatic cyc(input bit vin, input bit rdy, input bit st = 0,
                       input int sw = 0, input int sh = 0, input bit clr = 0);
        bit act_pre, drain_pre, exp_rdy, done_next;
        beat_t b;
        @(negedge clk);
        chk("frame_done", 64'(frame_done), 64'(done_exp));
        chk("busy",       64'(busy),       64'(active));
        chk("err_unexp",  64'(err_unexp),  64'(err_exp));
        chk("out_valid",  64'(out_valid),  64'(pend.size() != 0));
        if (pend.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(pend[0].d));
            chk("out_strb", 64'(out_strb), 64'(pend[0].s));
            chk("out_eol",  64'(out_eol),  64'(pend[0].eol));
            chk("out_last", 64'(out_last), 64'(pend[0].last));
        end
        in_valid  = vin;
        in_data   = $urandom;
        in_strb   = 4'($urandom_range(0, 15));
        out_ready = rdy;
        start     = st;
        width     = CW'(sw);
        height    = CW'(sh);
        clear     = clr;
        #1;
        act_pre   = active;
        drain_pre = active && (acc_cnt == total);
        exp_rdy   = act_pre && (acc_cnt < total) && (pend.size() == 0 || rdy);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        done_next = 0;
        if (pend.size() != 0 && rdy) begin
            b = pend.pop_front();
            if (b.last) begin
                active    = 0;
                done_next = 1;
            end
        end
        if (vin && exp_rdy) begin
            b.d    = in_data;
            b.s    = in_strb;
            b.eol  = (acc_cnt % fw) == fw - 1;
            b.last = (acc_cnt == total - 1);
            pend.push_back(b);
            acc_cnt++;
        end
        if (st && !act_pre && sw != 0 && sh != 0) begin
            active = 1; fw = sw; fh = sh; total = sw * sh; acc_cnt = 0; err_exp = 0;
        end else begin
            if (st && !act_pre) done_next = 1;
            if (vin && (!act_pre || drain_pre)) err_exp = 1;
        end
        if (clr) begin
            active = 0; acc_cnt = 0; err_exp = 0; done_next = 0;
            pend.delete();
        end
        done_exp = done_next;
    endtask

    task automatic run_frame(input int w, input int h, input int pv, input int pr);
        int budget;
        cyc(0, 1, 1, w, h);
        budget = 600;
        while (active && budget > 0) begin
            cyc($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr);
            budget--;
        end
        chk("frame_timeout", 64'(active), 0);
        cyc(0, 1);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk_all_zero(tag);
        model_reset();
        in_valid = 0; start = 0; clear = 0;
        @(negedge clk);
        #2;
        rst_n = 1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; fw = 1; fh = 1;
        model_reset();
        rst_n = 0; clear = 0; start = 0; width = 0; height = 0;
        in_data = 0; in_strb = 0; in_valid = 0; out_ready = 0;
        #3;
        chk_all_zero("reset");
        #10;
        rst_n = 1;

        // Full-throughput 3x2 frame.
        cyc(0, 1, 1, 3, 2);
        repeat (9) cyc(1, 1);
        cyc(0, 1);

        // 4x1 frame with downstream ready toggling every cycle.
        cyc(0, 1, 1, 4, 1);
        for (int i = 0; i < 12; i++) cyc(1, i[0]);
        cyc(0, 1);

        // Zero-dimension start: immediate done, never busy.
        cyc(0, 1, 1, 0, 5);
        repeat (3) cyc(0, 1);

        // Unexpected input in IDLE, then cleared by an accepted start.
        cyc(1, 1);
        cyc(1, 1);
        cyc(0, 1);
        run_frame(2, 1, 100, 100);

        // Asynchronous reset mid-frame with a beat held.
        cyc(0, 1, 1, 4, 2);
        while (acc_cnt < 3) cyc(1, 1);
        cyc(0, 0);
        async_reset("midreset");
        cyc(0, 1);
        run_frame(2, 2, 100, 100);

        // Soft clear coinciding with an input handshake.
        cyc(0, 1, 1, 3, 3);
        cyc(1, 1);
        cyc(1, 1);
        cyc(1, 1, 0, 0, 0, 1);
        repeat (2) cyc(1, 1);
        cyc(0, 1);
        run_frame(3, 1, 100, 100);

        // Randomized frames, including the maximal 7x7 dimension.
        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(1, 7), $urandom_range(1, 4), 70, 60);
        run_frame(7, 7, 80, 75);
        cyc(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_dataflow_out_framer.md
MULTI_DATAFLOW_OUT_FRAMER -- requirements
Module: multi_dataflow_out_framer

Sits between the kernel output stream and the HWPE source streamer. It registers each output beat, tags end-of-line and end-of-frame from width/height, and reports frame completion to the control FSM.

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width in bits.
REQ-002 Parameter CNT_WIDTH, default 16: width of the dimension inputs and the internal counters.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 clear_i  in  1  synchronous soft clear.
REQ-006 start_i  in  1  frame start; sampled only in IDLE.
REQ-007 width_i  in  CNT_WIDTH  beats per line; latched on an accepted start.
REQ-008 height_i  in  CNT_WIDTH  lines per frame; latched on an accepted start.
REQ-009 in_data_i  in  DATA_WIDTH  kernel output data.
REQ-010 in_strb_i  in  DATA_WIDTH/8  byte strobes.
REQ-011 in_valid_i  in  1  input beat valid.
REQ-012 in_ready_o  out  1  input beat ready.
REQ-013 out_data_o  out  DATA_WIDTH  registered data.
REQ-014 out_strb_o  out  DATA_WIDTH/8  registered strobes.
REQ-015 out_valid_o  out  1  output beat valid.
REQ-016 out_ready_i  in  1  downstream ready.
REQ-017 out_eol_o  out  1  current output beat is the last of its line.
REQ-018 out_last_o  out  1  current output beat is the last of the frame.
REQ-019 busy_o  out  1  high in RUN and DRAIN.
REQ-020 frame_done_o  out  1  one-cycle pulse at frame end.
REQ-021 err_unexp_o  out  1  sticky flag: input offered outside RUN.

Function
REQ-022 FSM states are IDLE, RUN and DRAIN; the state is IDLE after reset.
REQ-023 IDLE: start_i=1 with width_i!=0 and height_i!=0 latches both dimensions, clears col/row counters and err_unexp_o, and moves to RUN next cycle.
REQ-024 IDLE: start_i=1 with width_i==0 or height_i==0 stays in IDLE and pulses frame_done_o in the next cycle; no beats are accepted.
REQ-025 start_i is ignored in RUN and DRAIN.
REQ-026 in_ready_o = (state==RUN) & (~out_valid_o | out_ready_i); it is 0 in IDLE and DRAIN.
REQ-027 An input handshake (in_valid_i & in_ready_o) loads the output register; out_valid_o rises on the next cycle (latency 1).
REQ-028 At an input handshake, out_eol_o = (col==width-1) and out_last_o = out_eol_o & (row==height-1), captured together with the data.
REQ-029 col increments on each input handshake and wraps to 0 after width-1; row increments on each wrap.
REQ-030 The output register holds its data, strobes and tags stable while out_valid_o=1 and out_ready_i=0.
REQ-031 When the output is consumed and no new beat is accepted, out_valid_o drops on the next cycle.
REQ-032 Simultaneous output consume and input accept gives full throughput: one beat per cycle, no bubble.
REQ-033 Accepting the last beat of the frame moves RUN to DRAIN.
REQ-034 In DRAIN, the output handshake of the out_last_o beat pulses frame_done_o for exactly 1 cycle and returns the FSM to IDLE in that same cycle.
REQ-035 in_valid_i=1 while the state is IDLE or DRAIN sets err_unexp_o; it stays set until an accepted start or clear_i.
REQ-036 clear_i=1 has priority over all other inputs; on the next cycle the state is IDLE, out_valid_o=0, counters are 0, err_unexp_o=0 and frame_done_o=0.
REQ-037 Counter arithmetic is unsigned CNT_WIDTH bits; width=height=2^CNT_WIDTH-1 is fully supported with no overflow.

Reset
REQ-038 With rst_ni=0, immediately and independent of clk_i: state=IDLE, in_ready_o=0, out_valid_o=0, out_eol_o=0, out_last_o=0, busy_o=0, frame_done_o=0, err_unexp_o=0, out_data_o=0, out_strb_o=0, counters=0.
REQ-039 Reset asserted mid-frame discards any held beat; after release, the block waits in IDLE for a new start.

Verification
REQ-040 width=3, height=2, start, in_valid held high, out_ready held high -> 6 beats at 1 beat/cycle; out_eol_o set on beats 3 and 6; out_last_o set on beat 6 only; frame_done_o pulses once, 1 cycle after the beat-6 input handshake's output cycle.
REQ-041 width=4, height=1, out_ready toggled 1/0 every cycle -> data and tags stable while stalled; no beat lost or duplicated; 4 output handshakes.
REQ-042 start with width=0, height=5 -> no in_ready_o; frame_done_o pulses 1 cycle after start; busy_o stays 0.
REQ-043 in_valid_i=1 in IDLE -> err_unexp_o=1 and no beat accepted; the next accepted start clears it.
REQ-044 rst_ni pulled low after 3 of 8 beats, with out_valid_o=1 -> all outputs zero asynchronously; a subsequent start with width=2, height=2 completes normally.
REQ-045 clear_i asserted in the same cycle as an input handshake in RUN -> next cycle IDLE, out_valid_o=0, and the beat is dropped.
